entropy_decode_ac_run_coefficients: RTL

Bit-serial decoder for the AC run codewords produced by the slice entropy encoder. It sits on the decode path after the slice bitstream reader and before coefficient reconstruction. On each `start` it consumes one adaptive Rice/Exp-Golomb run codeword from a one-bit-per-cycle stream and returns the decoded run. It also tracks the previous run value, which selects the codebook for the next codeword.

---
 rtl/entropy_decode_ac_run_coefficients.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/entropy_decode_ac_run_coefficients.sv
// entropy_decode_ac_run_coefficients
//
// Bit-serial decoder for adaptive Rice / Exp-Golomb AC run codewords. Each
// accepted start consumes one codeword (one bit per cycle, MSB first) and
// returns the decoded run. The previous run selects the codebook for the
// next codeword; slice_start resets that history to 4.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   slice_start  strobe: prev_run <- 4, abort any decode, go IDLE
//   start        decode request, sampled only in IDLE
//   bit_in       bitstream bit
//   bit_valid    bit_in is valid this cycle
//   bit_ready    decoder consumes bit_in this cycle when bit_valid is high
//   busy         decoder is in PREFIX or SUFFIX
//   run_valid    one-cycle pulse, run holds a fresh value
//   run          decoded run, held until the next run_valid
//   error        one-cycle pulse on prefix overflow (16 zeros)

module entropy_decode_ac_run_coefficients (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        slice_start,
  input  logic        start,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  output logic        busy,
  output logic        run_valid,
  output logic [31:0] run,
  output logic        error
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PREFIX = 2'd1;
  localparam logic [1:0] ST_SUFFIX = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  z_q, z_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  n_q, n_d;
  logic        rice_q, rice_d;
  logic [2:0]  s_q, s_d;
  logic [1:0]  qlim_q, qlim_d;
  logic        kr_q, kr_d;
  logic [1:0]  ke_q, ke_d;
  logic [31:0] prev_q, prev_d;
  logic [31:0] run_q, run_d;
  logic        run_valid_q, run_valid_d;
  logic        error_q, error_d;

  // Codebook fields derived from the previous run value
  logic [2:0] cb_s;
  logic [1:0] cb_q;
  logic       cb_kr;
  logic [1:0] cb_ke;

  logic       finish;
  logic [4:0] eg_len;

  // Exp-Golomb value: acc holds 1 followed by the suffix bits; removing the
  // implicit (1<<ke) and adding the switch point gives the run.
  function automatic logic [31:0] eg_run(input logic [31:0] acc,
                                         input logic [1:0]  ke,
                                         input logic [2:0]  s);
    eg_run = acc - (32'd1 << ke) + {29'd0, s};
  endfunction

  always_comb begin
    cb_s  = 3'd0;
    cb_q  = 2'd0;
    cb_kr = 1'b0;
    cb_ke = 2'd0;
    if (prev_q <= 32'd1) begin
      cb_s = 3'd3; cb_q = 2'd3; cb_kr = 1'b0; cb_ke = 2'd1;
    end else if (prev_q <= 32'd3) begin
      cb_s = 3'd2; cb_q = 2'd2; cb_kr = 1'b0; cb_ke = 2'd1;
    end else if (prev_q == 32'd4) begin
      cb_s = 3'd0; cb_q = 2'd0; cb_kr = 1'b0; cb_ke = 2'd0;
    end else if (prev_q <= 32'd8) begin
      cb_s = 3'd4; cb_q = 2'd2; cb_kr = 1'b1; cb_ke = 2'd2;
    end else if (prev_q <= 32'd14) begin
      cb_s = 3'd0; cb_q = 2'd0; cb_kr = 1'b0; cb_ke = 2'd1;
    end else begin
      cb_s = 3'd0; cb_q = 2'd0; cb_kr = 1'b0; cb_ke = 2'd2;
    end
  end

  // z >= Q on this path, so the subtraction cannot wrap; max is 15+2 = 17.
  assign eg_len = z_q - {3'd0, qlim_q} + {3'd0, ke_q};

  always_comb begin
    state_d     = state_q;
    z_d         = z_q;
    acc_d       = acc_q;
    n_d         = n_q;
    rice_d      = rice_q;
    s_d         = s_q;
    qlim_d      = qlim_q;
    kr_d        = kr_q;
    ke_d        = ke_q;
    prev_d      = prev_q;
    run_d       = run_q;
    run_valid_d = 1'b0;
    error_d     = 1'b0;
    finish      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PREFIX;
          z_d     = 5'd0;
          acc_d   = 32'd0;
          s_d     = cb_s;
          qlim_d  = cb_q;
          kr_d    = cb_kr;
          ke_d    = cb_ke;
        end
      end
      ST_PREFIX: begin
        if (bit_valid) begin
          if (!bit_in) begin
            z_d = z_q + 5'd1;
            if (z_q == 5'd15) begin
              error_d = 1'b1;
              state_d = ST_IDLE;
            end
          end else if (z_q < {3'd0, qlim_q}) begin
            rice_d = 1'b1;
            acc_d  = {27'd0, z_q};
            n_d    = {4'd0, kr_q};
            if (!kr_q) finish = 1'b1;
            else       state_d = ST_SUFFIX;
          end else begin
            rice_d = 1'b0;
            acc_d  = 32'd1;
            n_d    = eg_len;
            if (eg_len == 5'd0) finish = 1'b1;
            else                state_d = ST_SUFFIX;
          end
        end
      end
      ST_SUFFIX: begin
        if (bit_valid) begin
          acc_d = {acc_q[30:0], bit_in};
          n_d   = n_q - 5'd1;
          if (n_q == 5'd1) finish = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Result is formed on the edge that consumes the last bit so that
    // run/run_valid are registered and visible during the DONE cycle.
    if (finish) begin
      state_d     = ST_DONE;
      run_valid_d = 1'b1;
      run_d       = rice_d ? acc_d : eg_run(acc_d, ke_q, s_q);
      prev_d      = run_d;
    end

    // Slice boundary overrides everything, including a completing codeword.
    if (slice_start) begin
      state_d     = ST_IDLE;
      prev_d      = 32'd4;
      run_d       = run_q;
      run_valid_d = 1'b0;
      error_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      z_q         <= 5'd0;
      acc_q       <= 32'd0;
      n_q         <= 5'd0;
      rice_q      <= 1'b0;
      s_q         <= 3'd0;
      qlim_q      <= 2'd0;
      kr_q        <= 1'b0;
      ke_q        <= 2'd0;
      prev_q      <= 32'd4;
      run_q       <= 32'd0;
      run_valid_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      z_q         <= z_d;
      acc_q       <= acc_d;
      n_q         <= n_d;
      rice_q      <= rice_d;
      s_q         <= s_d;
      qlim_q      <= qlim_d;
      kr_q        <= kr_d;
      ke_q        <= ke_d;
      prev_q      <= prev_d;
      run_q       <= run_d;
      run_valid_q <= run_valid_d;
      error_q     <= error_d;
    end
  end

  assign busy      = (state_q == ST_PREFIX) || (state_q == ST_SUFFIX);
  assign bit_ready = busy;
  assign run_valid = run_valid_q;
  assign run       = run_q;
  assign error     = error_q;

endmodule
